// File: rtl/mod_counter.sv
// Modulo-N up/down counter with enable prescaler, synchronous clamped load,
// optional saturation at the range limits and a registered terminal-step pulse.
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             terminal;
    logic [WIDTH-1:0] step_val;

    assign tick     = en && (pre_cnt_q == PRE_LAST);
    assign terminal = up ? (count_q == MAX_VAL) : (count_q == '0);

    // Next value in modulo-MODULUS arithmetic, so MODULUS < 2**WIDTH never leaks out of range.
    always_comb begin
        step_val = count_q;
        if (up) begin
            step_val = terminal ? '0 : count_q + WIDTH'(1);
        end else begin
            step_val = terminal ? MAX_VAL : count_q - WIDTH'(1);
        end
    end

    always_comb begin
        count_d   = count_q;
        pre_cnt_d = pre_cnt_q;
        wrap_d    = 1'b0;
        if (load) begin
            count_d   = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            pre_cnt_d = '0;
        end else if (en) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);
            if (tick) begin
                wrap_d = terminal;
                if (!((SATURATE != 0) && terminal)) begin
                    count_d = step_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            pre_cnt_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            wrap_q    <= wrap_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: four parameterisations driven side by side and checked
// against a behavioural model built from plain modular arithmetic.
module tb_mod_counter;
    localparam int NI = 4;
    localparam int MODV [NI] = '{10, 10, 10, 16};
    localparam int PREV [NI] = '{1, 3, 1, 2};
    localparam int SATV [NI] = '{0, 0, 1, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic       en_i   [NI];
    logic       up_i   [NI];
    logic       load_i [NI];
    logic [3:0] lv_i   [NI];
    logic [3:0] cnt_o  [NI];
    logic       wrap_o [NI];
    logic       max_o  [NI];
    logic       zero_o [NI];

    int m_cnt  [NI];
    int m_pre  [NI];
    int m_wrap [NI];
    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u0 (
        .clk(clk), .reset(reset), .en(en_i[0]), .up(up_i[0]), .load(load_i[0]), .load_val(lv_i[0]),
        .count(cnt_o[0]), .wrap(wrap_o[0]), .at_max(max_o[0]), .at_zero(zero_o[0]));
    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u1 (
        .clk(clk), .reset(reset), .en(en_i[1]), .up(up_i[1]), .load(load_i[1]), .load_val(lv_i[1]),
        .count(cnt_o[1]), .wrap(wrap_o[1]), .at_max(max_o[1]), .at_zero(zero_o[1]));
    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u2 (
        .clk(clk), .reset(reset), .en(en_i[2]), .up(up_i[2]), .load(load_i[2]), .load_val(lv_i[2]),
        .count(cnt_o[2]), .wrap(wrap_o[2]), .at_max(max_o[2]), .at_zero(zero_o[2]));
    mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(2), .SATURATE(0)) u3 (
        .clk(clk), .reset(reset), .en(en_i[3]), .up(up_i[3]), .load(load_i[3]), .load_val(lv_i[3]),
        .count(cnt_o[3]), .wrap(wrap_o[3]), .at_max(max_o[3]), .at_zero(zero_o[3]));

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
        end
    endtask

    // One clock edge of the reference: every PRESCALE-th enabled cycle moves the count by +/-1 mod MODULUS.
    task automatic model_clock(int i);
        bit ticked, term;
        if (load_i[i]) begin
            m_cnt[i]  = (int'(lv_i[i]) > MODV[i] - 1) ? MODV[i] - 1 : int'(lv_i[i]);
            m_pre[i]  = 0;
            m_wrap[i] = 0;
        end else if (en_i[i]) begin
            ticked   = ((m_pre[i] + 1) == PREV[i]);
            m_pre[i] = (m_pre[i] + 1) % PREV[i];
            m_wrap[i] = 0;
            if (ticked) begin
                term      = up_i[i] ? (m_cnt[i] == MODV[i] - 1) : (m_cnt[i] == 0);
                m_wrap[i] = term;
                if (!(SATV[i] != 0 && term))
                    m_cnt[i] = (m_cnt[i] + (up_i[i] ? 1 : MODV[i] - 1)) % MODV[i];
            end
        end else begin
            m_wrap[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_clock(i);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            en_i[i] = 1'b0; up_i[i] = 1'b1; load_i[i] = 1'b0; lv_i[i] = 4'd0;
        end
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b1;
        #5;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            checks++; if (cnt_o[i] !== 4'd0) begin errors++; $display("FAIL reset_count inst=%0d got %0d exp 0", i, cnt_o[i]); end
            checks++; if (wrap_o[i] !== 1'b0) begin errors++; $display("FAIL reset_wrap inst=%0d got %b exp 0", i, wrap_o[i]); end
            checks++; if (zero_o[i] !== 1'b1) begin errors++; $display("FAIL reset_at_zero inst=%0d got %b exp 1", i, zero_o[i]); end
            checks++; if (max_o[i] !== 1'b0) begin errors++; $display("FAIL reset_at_max inst=%0d got %b exp 0", i, max_o[i]); end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        en_i[0] = 1'b1; up_i[0] = 1'b1;
        repeat (7) step();
        checks++; if (cnt_o[0] !== 4'd7) begin errors++; $display("FAIL async_pre_count got %0d exp 7", cnt_o[0]); end
        en_i[0] = 1'b0;
        #19 reset = 1'b1;
        #1 model_reset();
        checks++; if (cnt_o[0] !== 4'd0) begin errors++; $display("FAIL async_count got %0d exp 0", cnt_o[0]); end
        checks++; if (wrap_o[0] !== 1'b0) begin errors++; $display("FAIL async_wrap got %b exp 0", wrap_o[0]); end
        checks++; if (zero_o[0] !== 1'b1) begin errors++; $display("FAIL async_at_zero got %b exp 1", zero_o[0]); end
        #8 reset = 1'b0;
        en_i[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (cnt_o[0] !== 4'(k)) begin errors++; $display("FAIL async_resume k=%0d got %0d exp %0d", k, cnt_o[0], k); end
        end
        en_i[0] = 1'b0;
    endtask

    task automatic test_up_wrap();
        int wraps = 0;
        load_i[0] = 1'b1; lv_i[0] = 4'd0;
        step();
        load_i[0] = 1'b0; en_i[0] = 1'b1; up_i[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (wrap_o[0] === 1'b1) wraps++;
            checks++; if (cnt_o[0] !== 4'(k % 10)) begin errors++; $display("FAIL up_wrap_count k=%0d got %0d exp %0d", k, cnt_o[0], k % 10); end
            checks++; if (wrap_o[0] !== (k == 10)) begin errors++; $display("FAIL up_wrap_pulse k=%0d got %b exp %b", k, wrap_o[0], k == 10); end
        end
        checks++; if (wraps != 1) begin errors++; $display("FAIL up_wrap_total got %0d exp 1", wraps); end
        en_i[0] = 1'b0;
    endtask

    task automatic test_down_wrap();
        int exp_seq [4] = '{2, 1, 0, 9};
        load_i[0] = 1'b1; lv_i[0] = 4'd2;
        step();
        load_i[0] = 1'b0; en_i[0] = 1'b1; up_i[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            checks++; if (cnt_o[0] !== 4'(exp_seq[k])) begin errors++; $display("FAIL down_count k=%0d got %0d exp %0d", k, cnt_o[0], exp_seq[k]); end
            checks++; if (wrap_o[0] !== (exp_seq[k] == 9)) begin errors++; $display("FAIL down_wrap k=%0d got %b exp %b", k, wrap_o[0], exp_seq[k] == 9); end
            checks++; if (zero_o[0] !== (exp_seq[k] == 0)) begin errors++; $display("FAIL down_at_zero k=%0d got %b exp %b", k, zero_o[0], exp_seq[k] == 0); end
        end
        en_i[0] = 1'b0;
    endtask

    task automatic test_load_clamp();
        // Count sits at 9: if enable won over load the counter would wrap to 0.
        en_i[0] = 1'b1; up_i[0] = 1'b1; load_i[0] = 1'b1; lv_i[0] = 4'd13;
        step();
        checks++; if (cnt_o[0] !== 4'd9) begin errors++; $display("FAIL clamp_count got %0d exp 9", cnt_o[0]); end
        checks++; if (wrap_o[0] !== 1'b0) begin errors++; $display("FAIL clamp_wrap got %b exp 0", wrap_o[0]); end
        checks++; if (max_o[0] !== 1'b1) begin errors++; $display("FAIL clamp_at_max got %b exp 1", max_o[0]); end
        lv_i[0] = 4'd5;
        step();
        checks++; if (cnt_o[0] !== 4'd5) begin errors++; $display("FAIL load_no_step got %0d exp 5", cnt_o[0]); end
        lv_i[0] = 4'd15;
        step();
        checks++; if (cnt_o[0] !== 4'd9) begin errors++; $display("FAIL clamp15_count got %0d exp 9", cnt_o[0]); end
        load_i[0] = 1'b0; en_i[0] = 1'b0;
    endtask

    task automatic test_prescale();
        int exp_a [13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        load_i[1] = 1'b1; lv_i[1] = 4'd0;
        step();
        load_i[1] = 1'b0; up_i[1] = 1'b1;
        // en pattern then expected count after each edge
        for (int k = 1; k <= 9; k++) begin
            en_i[1] = 1'b1; step();
            checks++; if (cnt_o[1] !== 4'(k / 3)) begin errors++; $display("FAIL pre_run k=%0d got %0d exp %0d", k, cnt_o[1], k / 3); end
        end
        for (int k = 0; k < 5; k++) begin
            en_i[1] = 1'b0; step();
            checks++; if (cnt_o[1] !== 4'd3) begin errors++; $display("FAIL pre_hold k=%0d got %0d exp 3", k, cnt_o[1]); end
        end
        begin
            int exp_b [8] = '{3, 3, 4, 4, 4, 4, 4, 5};
            logic en_b [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
            for (int k = 0; k < 8; k++) begin
                en_i[1] = en_b[k]; step();
                if (k == 7) begin en_i[1] = 1'b1; step(); end
                checks++; if (cnt_o[1] !== 4'(exp_b[k] + ((k == 7) ? 0 : 0))) begin
                    errors++; $display("FAIL pre_phase k=%0d got %0d exp %0d", k, cnt_o[1], exp_b[k]);
                end
            end
        end
        // two enabled cycles into a step, then an async reset must discard the phase
        en_i[1] = 1'b1; step(); step();
        checks++; if (cnt_o[1] !== 4'd5) begin errors++; $display("FAIL pre_mid got %0d exp 5", cnt_o[1]); end
        #10 reset = 1'b1;
        #1 model_reset();
        #5 reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (cnt_o[1] !== 4'(k / 3)) begin errors++; $display("FAIL pre_after_reset k=%0d got %0d exp %0d", k, cnt_o[1], k / 3); end
            checks++; if (wrap_o[1] !== 1'b0) begin errors++; $display("FAIL pre_after_reset_wrap k=%0d got %b exp 0", k, wrap_o[1]); end
        end
        en_i[1] = 1'b0;
        if (exp_a[0] == 2) $display("unused");
    endtask

    task automatic test_saturate();
        int  exp_c [6] = '{8, 9, 9, 9, 9, 0};
        logic exp_w [6] = '{0, 0, 1, 1, 0, 0};
        logic en_c  [6] = '{0, 1, 1, 1, 0, 0};
        logic ld_c  [6] = '{1, 0, 0, 0, 0, 1};
        int  lv_c  [6] = '{8, 0, 0, 0, 0, 0};
        up_i[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            en_i[2] = en_c[k]; load_i[2] = ld_c[k]; lv_i[2] = 4'(lv_c[k]);
            step();
            checks++; if (cnt_o[2] !== 4'(exp_c[k])) begin errors++; $display("FAIL sat_count k=%0d got %0d exp %0d", k, cnt_o[2], exp_c[k]); end
            checks++; if (wrap_o[2] !== exp_w[k]) begin errors++; $display("FAIL sat_wrap k=%0d got %b exp %b", k, wrap_o[2], exp_w[k]); end
        end
        load_i[2] = 1'b0; en_i[2] = 1'b1; up_i[2] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (cnt_o[2] !== 4'd0) begin errors++; $display("FAIL sat_down_count k=%0d got %0d exp 0", k, cnt_o[2]); end
            checks++; if (wrap_o[2] !== 1'b1) begin errors++; $display("FAIL sat_down_wrap k=%0d got %b exp 1", k, wrap_o[2]); end
        end
        en_i[2] = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NI; i++) begin
                en_i[i]   = ($urandom_range(0, 3) != 0);
                up_i[i]   = ($urandom_range(0, 4) != 0) ? up_i[i] : ~up_i[i];
                load_i[i] = ($urandom_range(0, 19) == 0);
                lv_i[i]   = 4'($urandom_range(0, 15));
            end
            step();
            for (int i = 0; i < NI; i++) begin
                checks++; if (cnt_o[i] !== 4'(m_cnt[i])) begin errors++; $display("FAIL rnd_count n=%0d inst=%0d got %0d exp %0d", n, i, cnt_o[i], m_cnt[i]); end
                checks++; if (wrap_o[i] !== 1'(m_wrap[i])) begin errors++; $display("FAIL rnd_wrap n=%0d inst=%0d got %b exp %0d", n, i, wrap_o[i], m_wrap[i]); end
                checks++; if (max_o[i] !== (m_cnt[i] == MODV[i] - 1)) begin errors++; $display("FAIL rnd_at_max n=%0d inst=%0d got %b", n, i, max_o[i]); end
                checks++; if (zero_o[i] !== (m_cnt[i] == 0)) begin errors++; $display("FAIL rnd_at_zero n=%0d inst=%0d got %b", n, i, zero_o[i]); end
            end
            if ($urandom_range(0, 99) == 0) begin
                #10 reset = 1'b1;
                #1 model_reset();
                checks++; if (cnt_o[3] !== 4'd0 || wrap_o[3] !== 1'b0) begin
                    errors++; $display("FAIL rnd_reset n=%0d got count %0d wrap %b exp 0 0", n, cnt_o[3], wrap_o[3]);
                end
                #5 reset = 1'b0;
            end
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_prescale();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: count register width in bits.
REQ-002 Parameter MODULUS, default 10: count range is 0..MODULUS-1; legal values 2..2**WIDTH.
REQ-003 Parameter PRESCALE, default 1: number of enabled cycles per count step; legal values >= 1.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at the range limits, 1 = hold at the range limits.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  count enable; advances the prescaler.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 count  output  WIDTH  registered count value.
REQ-012 wrap  output  1  registered one-cycle pulse on a terminal step.
REQ-013 at_max  output  1  combinational; high when count == MODULUS-1.
REQ-014 at_zero  output  1  combinational; high when count == 0.

Function
REQ-015 Tick generation:
- Internal prescaler pre_cnt, range 0..PRESCALE-1.
- When en=1, pre_cnt increments and wraps to 0 after PRESCALE-1.
- When en=0, pre_cnt holds.
- tick = en && (pre_cnt == PRESCALE-1); with PRESCALE=1, every enabled cycle is a tick.
REQ-016 Up tick, count < MODULUS-1: count <= count+1, wrap <= 0.
REQ-017 Up tick, count == MODULUS-1:
- SATURATE=0: count <= 0.
- SATURATE=1: count holds.
- Either mode: wrap <= 1.
REQ-018 Down tick, count > 0: count <= count-1, wrap <= 0.
REQ-019 Down tick, count == 0:
- SATURATE=0: count <= MODULUS-1.
- SATURATE=1: count holds.
- Either mode: wrap <= 1.
REQ-020 Non-tick cycle without load: count holds, wrap <= 0; wrap is never high for two cycles unless two consecutive ticks are terminal.
REQ-021 Load behaviour:
- Load has priority over en.
- count <= min(load_val, MODULUS-1).
- pre_cnt <= 0, wrap <= 0.
- No count step occurs in that cycle.
REQ-022 A change of up takes effect on the next tick; it does not reset pre_cnt.
REQ-023 Latency: count and wrap reflect a tick or load one clock edge after the cycle in which it is sampled; wrap coincides with the post-step count.
REQ-024 count never holds a value >= MODULUS after reset.
REQ-025 Arithmetic is performed modulo MODULUS, never modulo 2**WIDTH.

Reset
REQ-026 While reset=1, immediately and independent of clk: count=0, pre_cnt=0, wrap=0; at_zero=1 and at_max=0 follow.
REQ-027 Reset asserted mid-count or mid-prescale aborts the operation; no tick and no wrap pulse are produced from the pre-reset state.
REQ-028 The first tick after reset deasserts occurs PRESCALE enabled cycles later.

Verification (defaults WIDTH=4, MODULUS=10, PRESCALE=1, SATURATE=0 unless stated)
REQ-029 Async reset: at count=7, assert reset 20 ns between clock edges -> count=0 and wrap=0 before the next rising edge; after release, counting resumes 1,2,...
REQ-030 Up wrap: en=1, up=1 from 0 for 12 cycles -> count 1..9,0,1,2; wrap high for exactly one cycle, coincident with count=0.
REQ-031 Down wrap: load_val=2, then en=1, up=0 -> count 2,1,0,9; wrap high coincident with count=9; at_zero high only while count=0.
REQ-032 Load clamp and priority: load=1, load_val=13, en=1 -> next count=9, no step in that cycle, wrap=0, at_max=1.
REQ-033 Prescaler (PRESCALE=3): en=1 for 9 cycles -> count=3. Then en=0 for 5 cycles -> count and prescale phase hold. Then en=1 -> next step exactly 3 enabled cycles after the previous step.
REQ-034 Saturate (SATURATE=1): load 8, then up ticks x3 -> count 9,9,9; wrap pulses on the 2nd and 3rd ticks; down from 0 -> count stays 0 with wrap pulse.
